piso_tx_scheduler: RTL
======================

// Module: piso_tx_scheduler
// PURPOSE
//   Shares one parallel-in/serial-out shifter between NREQ requesters.
//   Picks a requester round-robin, captures its WIDTH-bit word, and
//   shifts it out MSB-first, one bit per clock, with valid/last framing.
//   It then inserts GAP idle cycles before the next arbitration.
//   Sits between word producers and a single-wire serial sink.
// PARAMETERS
//   WIDTH   4   bits per word / shift register length (>=2)
//   NREQ    4   number of requesters (>=2)
//   GAP     1   idle cycles after ser_last before next arbitration (>=0)
// PORTS
//   clk       in   1            system clock, rising edge
//   rst       in   1            asynchronous, active-low reset
//   req       in   NREQ         per-requester request level
//   data      in   NREQ*WIDTH   requester i word at data[i*WIDTH +: WIDTH]
//   ack       out  NREQ         one-cycle pulse: requester i word captured
//   ser_out   out  1            serial data, MSB first
//   ser_valid out  1            ser_out carries a frame bit this cycle
//   ser_last  out  1            final bit of frame (with ser_valid)
//   gnt_id    out  clog2(NREQ)  index of last/current granted requester
//   busy      out  1            high in SHIFT and GAP states
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, all outputs 0, shifter cleared,
//     bit/gap counters 0, RR pointer=NREQ-1 (requester 0 wins first).
//   States: IDLE -> SHIFT -> GAP -> IDLE (GAP skipped when GAP==0).
//   IDLE: req sampled only here. If any req bit is set, search from
//     pointer+1 mod NREQ upward and take the first set bit k.
//     At that edge: load shifter with data[k], gnt_id<=k, pointer<=k,
//     ack[k]<=1, state<=SHIFT. No req set: stay IDLE, outputs 0.
//   SHIFT: WIDTH cycles, ser_valid=1, ser_out=shifter MSB, shift left
//     with 0 fill each edge; ack falls after its first cycle.
//     ser_last=1 on the WIDTH-th cycle. Next state: GAP, or IDLE if GAP==0.
//   GAP: GAP cycles, ser_valid=0, ser_out=0, busy=1, then IDLE.
//   Latency: grant edge -> first bit 1 cycle. Frame period under
//     continuous req = 1 + WIDTH + GAP cycles (6 at defaults).
//   Requester contract: hold req and data stable until ack is seen.
//     Drop req before the next IDLE cycle, or it is a new request.
//     Data changes after capture do not affect the frame in flight.
//   ser_out=0 whenever ser_valid=0. All outputs registered.
//   Reset mid-frame: frame aborted immediately, no resume.
//     After release, arbitration restarts from requester 0.
//   Single requester held high: served every frame period, no starvation.
// STRUCTURE
//   Shared include piso_ctrl_defs.vh: state encodings S_IDLE/S_SHIFT/
//     S_GAP, CLOG2 helper function for the gnt_id and counter widths.
//   Sub-module piso_shifter (WIDTH; clk, rst, load, shift, d, q_msb):
//     async active-low clear, load has priority over shift.
//   Top holds the FSM, bit counter, gap counter and RR pointer/search.
// TESTING (WIDTH=4, NREQ=4, GAP=1 unless noted)
//   Reset: rst=0 mid-run -> ack=0, ser_*=0, busy=0, gnt_id=0 immediately.
//   Single: req=0001, data0=0101 -> ack[0] pulse 1 cycle after grant;
//     ser_out 0,1,0,1 over 4 valid cycles, ser_last on 4th, then 1 idle.
//   Full RR: req=1111 held, data_i=i+8 -> gnt_id order 0,1,2,3,0;
//     ser_last pulses exactly 6 cycles apart.
//   Sparse RR: req=0101 held -> order 0,2,0,2; requesters 1,3 never acked.
//   Abort: rst pulsed after 2 bits of requester 2's frame -> outputs 0 now.
//     After release with req=0101, requester 0 is served with a full 4 bits.
//   GAP=0 build, req=0011 held -> frames alternate 0,1, period 5 cycles,
//     ser_valid low exactly 1 cycle between frames.

Source files
------------

// File: rtl/piso_tx_scheduler_pkg.sv
// Shared definitions for the PISO transmit scheduler: FSM encodings and
// a constant-width helper.
package piso_tx_scheduler_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Bits needed to index value distinct items (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// WIDTH-bit parallel-load, left-shifting register with zero fill.
// Load wins over shift; the MSB is the serial output.
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next shifter contents
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shifter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_msb = sr_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one PISO shifter between NREQ requesters,
// framing each word with valid/last and inserting GAP idle cycles.
module piso_tx_scheduler
  import piso_tx_scheduler_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  parameter  int GAP   = 1,
  localparam int IW    = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_last,
  output logic [IW-1:0]         gnt_id,
  output logic                  busy
);

  localparam int             BW       = clog2(WIDTH);
  localparam int             GW       = clog2(GAP + 2);
  localparam int             GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_M1);
  localparam logic [IW-1:0]  PTR_RST  = IW'(NREQ - 1);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gnt_id_q, gnt_id_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;

  logic             found_s;
  logic [IW-1:0]    pick_s;
  logic [IW-1:0]    idx_s;
  logic             grant_s;
  logic             shift_s;
  logic [WIDTH-1:0] word_s;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_s   = IW'((int'(ptr_q) + i) % NREQ);
      pick_s  = (!found_s && req[idx_s]) ? idx_s : pick_s;
      found_s = found_s | req[idx_s];
    end
  end

  assign word_s  = data[int'(pick_s)*WIDTH +: WIDTH];
  assign shift_s = (state_q == S_SHIFT);

  // FSM, counters, pointer and next registered output values
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    ack_d     = '0;
    grant_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          grant_s   = 1'b1;
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          ptr_d     = pick_s;
          gnt_id_d  = pick_s;
          ack_d     = NREQ'(1) << pick_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ser_valid_d = (state_d == S_SHIFT);
    ser_last_d  = (state_d == S_SHIFT) && (bit_cnt_d == BIT_LAST);
    busy_d      = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ptr_q       <= PTR_RST;
      gnt_id_q    <= '0;
      ack_q       <= '0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      ack_q       <= ack_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end

  // The shifter drains to zero by the end of a frame, so its MSB is 0 outside SHIFT.
  piso_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (grant_s),
    .shift (shift_s),
    .d     (word_s),
    .q_msb (ser_out)
  );

  assign ack       = ack_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;

endmodule
